// File: rtl/cl_fmt_pkg.sv
// cl_fmt_pkg: shared types and constants for the Camera Link frame formatter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cl_fmt_pkg;

  localparam int CL_TAPS     = 8;
  localparam int CL_TAP_W    = 8;
  localparam int FRAME_CNT_W = 16;

  // Frame gating FSM: a frame is only emitted if the block was ARMED before its fval rise.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    ARMED    = 2'd2,
    FRAME    = 2'd3
  } fmt_state_t;

endpackage

// File: rtl/cl_line_crop.sv
// cl_line_crop: column counter, horizontal crop window and short-line detect for one line stream.
// Latency: combinational window/short outputs; the caller registers them (counter state is internal).
// Backpressure: none; one tap group per clock.
module cl_line_crop #(
  parameter int COL_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_in,
  input  logic [COL_W-1:0] win_start,
  input  logic [COL_W-1:0] win_len,
  output logic             win,
  output logic             short_line
);

  localparam logic [COL_W-1:0] COL_MAX = '1;

  logic             line_q;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_next_sat;
  logic [COL_W-1:0] col_cur;
  logic [COL_W:0]   win_end;

  // Column of the current cycle: 0 on the first lval cycle, then +1 saturating at COL_MAX.
  assign col_next_sat = (col_q == COL_MAX) ? COL_MAX : col_q + COL_W'(1);
  assign col_cur      = line_q ? col_next_sat : '0;

  // Window end is one bit wider so start + length never wraps.
  assign win_end = {1'b0, win_start} + {1'b0, win_len};

  assign win = line_in
            && ({1'b0, col_cur} >= {1'b0, win_start})
            && ({1'b0, col_cur} <  win_end);

  // At the lval fall col_next_sat is the number of columns seen (saturated).
  assign short_line = line_q && !line_in && (win_len != '0)
                   && ({1'b0, col_next_sat} < win_end);

  // Track line activity and the column of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b0;
      col_q  <= '0;
    end else begin
      line_q <= line_in;
      col_q  <= line_in ? col_cur : '0;
    end
  end

endmodule

// File: rtl/cl_frame_formatter.sv
// cl_frame_formatter: crops raw tap lines and emits only whole Camera Link frames (fval/lval/dval/taps).
// Latency: 2 clk_txg cycles for every output (input register stage, then output register stage).
// Backpressure: none, free-running stream; CL_FRAME_STAMP_EN puts frame_cnt on taps 0/1 of a frame's first dval.
module cl_frame_formatter
  import cl_fmt_pkg::*;
#(
  parameter int CHAN_W   = CL_TAP_W,
  parameter int NUM_CHAN = CL_TAPS,
  parameter int COL_W    = 12
) (
  input  logic                       clk_txg,
  input  logic                       rst_tx_n,
  input  logic                       enable,
  input  logic [COL_W-1:0]           reg_h_start,
  input  logic [COL_W-1:0]           reg_h_length,
  input  logic                       fval_in,
  input  logic                       lval_in,
  input  logic [NUM_CHAN*CHAN_W-1:0] chan_in,
  input  logic                       err_clear,
  output logic                       fval,
  output logic                       lval,
  output logic                       dval,
  output logic [NUM_CHAN*CHAN_W-1:0] chan_out,
  output logic [FRAME_CNT_W-1:0]     frame_cnt,
  output logic [COL_W-1:0]           line_cnt,
  output logic                       err_short_line
);

  localparam logic [COL_W-1:0] LINE_MAX = '1;

  logic                       enable_r;
  logic                       fval_r;
  logic                       lval_r;
  logic [COL_W-1:0]           start_r;
  logic [COL_W-1:0]           length_r;
  logic [NUM_CHAN*CHAN_W-1:0] chan_r;

  fmt_state_t                 state_q;
  fmt_state_t                 state_d;
  logic                       frame_load;
  logic                       frame_end;
  logic                       emit;

  logic [COL_W-1:0]           shadow_start;
  logic [COL_W-1:0]           shadow_len;
  logic [COL_W-1:0]           eff_start;
  logic [COL_W-1:0]           eff_len;

  logic                       win;
  logic                       short_line;
  logic [NUM_CHAN*CHAN_W-1:0] chan_sel;

  // Input register stage: everything enters through one flop so all paths share the same latency.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      enable_r <= 1'b0;
      fval_r   <= 1'b0;
      lval_r   <= 1'b0;
      start_r  <= '0;
      length_r <= '0;
      chan_r   <= '0;
    end else begin
      enable_r <= enable;
      fval_r   <= fval_in;
      lval_r   <= lval_in;
      start_r  <= reg_h_start;
      length_r <= reg_h_length;
      chan_r   <= chan_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame gating. ARMED is only ever entered with fval_r low, so fval_r high there is the rise.
  always_comb begin
    state_d    = state_q;
    frame_load = 1'b0;
    frame_end  = 1'b0;
    emit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_r) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!fval_r) state_d = ARMED;
      end
      ARMED: begin
        if (fval_r) begin
          frame_load = 1'b1;
          emit       = 1'b1;
          state_d    = FRAME;
        end
      end
      FRAME: begin
        if (fval_r) begin
          emit = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_d   = enable_r ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow crop registers, captured once per frame at the fval rise.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      shadow_start <= '0;
      shadow_len   <= '0;
    end else if (frame_load) begin
      shadow_start <= start_r;
      shadow_len   <= length_r;
    end
  end

  // The first frame cycle uses the values being captured so a line starting with fval is cropped correctly.
  assign eff_start = frame_load ? start_r  : shadow_start;
  assign eff_len   = frame_load ? length_r : shadow_len;

  // lval outside an emitted frame (including lval with fval low) never reaches the cropper.
  cl_line_crop #(
    .COL_W (COL_W)
  ) u_line_crop (
    .clk        (clk_txg),
    .rst_n      (rst_tx_n),
    .line_in    (lval_r & emit),
    .win_start  (eff_start),
    .win_len    (eff_len),
    .win        (win),
    .short_line (short_line)
  );

`ifdef CL_FRAME_STAMP_EN
  logic stamp_pending;
  logic stamp_now;

  assign stamp_now = win && (frame_load || stamp_pending);

  // Armed at every frame start, consumed by the first dval cycle of that frame.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      stamp_pending <= 1'b0;
    end else if (frame_load || stamp_pending) begin
      stamp_pending <= !win;
    end
  end

  // Replace taps 0/1 with the frame counter on the stamped cycle only.
  always_comb begin
    chan_sel = chan_r;
    if (stamp_now) begin
      chan_sel[CHAN_W-1:0]        = CHAN_W'(frame_cnt[7:0]);
      chan_sel[2*CHAN_W-1:CHAN_W] = CHAN_W'(frame_cnt[15:8]);
    end
  end
`else
  assign chan_sel = chan_r;
`endif

  // Output register stage for the Camera Link signals; taps are forced to zero outside lval.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      fval     <= 1'b0;
      lval     <= 1'b0;
      dval     <= 1'b0;
      chan_out <= '0;
    end else begin
      fval     <= emit;
      lval     <= win;
      dval     <= win;
      chan_out <= win ? chan_sel : '0;
    end
  end

  // Frame counter: bumps as the emitted fval falls, wrapping at 16 bits.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Line counter: cleared at frame start, counts output lval falls, saturates.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      line_cnt <= '0;
    end else if (frame_load) begin
      line_cnt <= '0;
    end else if (lval && !win && (line_cnt != LINE_MAX)) begin
      line_cnt <= line_cnt + COL_W'(1);
    end
  end

  // Sticky short-line flag; a new error in the same cycle beats err_clear.
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      err_short_line <= 1'b0;
    end else if (short_line) begin
      err_short_line <= 1'b1;
    end else if (err_clear) begin
      err_short_line <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cl_frame_formatter.sv
// tb_cl_frame_formatter: scoreboard bench for cl_frame_formatter.
// Expected beats/frame summaries are queued by the stimulus from a frame-level model; a negedge monitor pops them.
// Stimulus mixes the directed scenarios with randomized frames, crops and enable toggles.
module tb_cl_frame_formatter;

  logic        clk_txg      = 1'b0;
  logic        rst_tx_n     = 1'b0;
  logic        enable       = 1'b0;
  logic [11:0] reg_h_start  = '0;
  logic [11:0] reg_h_length = '0;
  logic        fval_in      = 1'b0;
  logic        lval_in      = 1'b0;
  logic [63:0] chan_in      = '0;
  logic        err_clear    = 1'b0;
  logic        fval, lval, dval, err_short_line;
  logic [63:0] chan_out;
  logic [15:0] frame_cnt;
  logic [11:0] line_cnt;

  always #5 clk_txg = ~clk_txg;

  cl_frame_formatter #(.CHAN_W(8), .NUM_CHAN(8), .COL_W(12)) dut (
    .clk_txg(clk_txg), .rst_tx_n(rst_tx_n), .enable(enable),
    .reg_h_start(reg_h_start), .reg_h_length(reg_h_length),
    .fval_in(fval_in), .lval_in(lval_in), .chan_in(chan_in), .err_clear(err_clear),
    .fval(fval), .lval(lval), .dval(dval), .chan_out(chan_out),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt), .err_short_line(err_short_line)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_beats[$];
  logic [27:0] exp_frames[$];   // {frame_cnt, line_cnt} expected at each emitted fval fall

  // Frame configuration read by run_frame.
  int          f_lines     = 1;
  int          f_len[8];
  int          f_en_line   = -1;
  logic        f_en_val    = 1'b0;
  int          f_chg_line  = -1;
  logic [11:0] f_chg_start = '0;
  int          f_rst_line  = -1;
  int          f_rst_col   = 0;

  int fc_m  = 0;    // frames emitted since reset
  bit err_m = 0;    // sticky short-line model

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every dval beat and every emitted frame end against the queues.
  logic mon_fval_prev = 1'b0;
  always @(negedge clk_txg) begin
    if (!rst_tx_n) begin
      mon_fval_prev = 1'b0;
    end else begin
      chk("lval_eq_dval", {63'd0, dval}, {63'd0, lval});
      if (dval) begin
        if (exp_beats.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected: got %0h expected none", chan_out);
        end else begin
          chk("beat_data", chan_out, exp_beats.pop_front());
        end
      end else begin
        chk("idle_taps_zero", chan_out, 64'd0);
      end
      if (mon_fval_prev && !fval) begin
        if (exp_frames.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_unexpected: got frame_cnt %0d expected no frame", frame_cnt);
        end else begin
          logic [27:0] e;
          e = exp_frames.pop_front();
          chk("frame_cnt", {48'd0, frame_cnt}, {48'd0, e[27:12]});
          chk("line_cnt", {52'd0, line_cnt}, {52'd0, e[11:0]});
        end
      end
      mon_fval_prev = fval;
    end
  end

  task automatic cyc(input logic f, input logic l, input logic [63:0] d);
    fval_in = f; lval_in = l; chan_in = d;
    @(posedge clk_txg); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_fval"},  {63'd0, fval}, 64'd0);
    chk({tag, "_lval"},  {63'd0, lval}, 64'd0);
    chk({tag, "_dval"},  {63'd0, dval}, 64'd0);
    chk({tag, "_taps"},  chan_out, 64'd0);
    chk({tag, "_fcnt"},  {48'd0, frame_cnt}, 64'd0);
    chk({tag, "_lcnt"},  {52'd0, line_cnt}, 64'd0);
    chk({tag, "_err"},   {63'd0, err_short_line}, 64'd0);
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1; cyc(0, 0, '0); err_clear = 1'b0;
    err_m = 0;
    chk("err_after_clear", {63'd0, err_short_line}, 64'd0);
  endtask

  // One frame: idle gap, fval porch, f_lines lines with 3-cycle blanking, then fval low.
  // Model: a frame is emitted iff enable was high during its leading gap; crop uses values at fval rise.
  task automatic run_frame();
    bit emit, first;
    int s, ln, lines_out, rst_hold;
    logic [63:0] d, e;
    logic [15:0] fcv;
    lines_out = 0; rst_hold = 0; first = 1;
    for (int i = 0; i < 6; i++) cyc(0, 0, '0);
    emit = enable;
    s = int'(reg_h_start); ln = int'(reg_h_length);
    cyc(1, 0, '0); cyc(1, 0, '0);
    for (int li = 0; li < f_lines; li++) begin
      int beats = 0;
      if (li == f_en_line)  enable = f_en_val;
      if (li == f_chg_line) reg_h_start = f_chg_start;
      for (int c = 0; c < f_len[li]; c++) begin
        int cs = (c > 4095) ? 4095 : c;
        d = {$urandom, $urandom};
        if (emit && cs >= s && cs < s + ln) begin
          e = d;
          fcv = fc_m[15:0];
`ifdef CL_FRAME_STAMP_EN
          if (first) begin e[7:0] = fcv[7:0]; e[15:8] = fcv[15:8]; end
`endif
          if (fcv == 16'hffff) e = e;
          first = 0;
          exp_beats.push_back(e);
          beats++;
        end
        cyc(1, 1, d);
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) rst_tx_n = 1'b1;
        end
        if (li == f_rst_line && c == f_rst_col) begin
          rst_tx_n = 1'b0; #1;
          check_zero_outputs("midframe_reset");
          exp_beats.delete();
          emit = 0; fc_m = 0; err_m = 0; rst_hold = 3;
        end
      end
      if (emit) begin
        int seen = (f_len[li] > 4095) ? 4095 : f_len[li];
        if (beats > 0) lines_out++;
        if (ln != 0 && seen < s + ln) err_m = 1;
      end
      cyc(1, 0, '0); cyc(1, 0, '0); cyc(1, 0, '0);
    end
    if (emit) begin
      fc_m = (fc_m + 1) & 16'hffff;
      exp_frames.push_back({16'(fc_m), 12'(lines_out)});
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, '0);
    chk("err_short_line", {63'd0, err_short_line}, {63'd0, err_m});
  endtask

  initial begin
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk_txg);
    #1 rst_tx_n = 1'b1;

    // Three full frames, 4 lines x 100 columns, crop 10..29.
    enable = 1'b1; reg_h_start = 12'd10; reg_h_length = 12'd20;
    f_lines = 4;
    for (int i = 0; i < 8; i++) f_len[i] = 100;
    repeat (3) run_frame();
    chk("frame_cnt_after_three", {48'd0, frame_cnt}, 64'd3);

    // Crop start changed mid-frame only takes effect on the next frame.
    f_chg_line = 1; f_chg_start = 12'd50; run_frame();
    f_chg_line = -1; run_frame();

    // Short line of 25 columns: 15 beats, sticky error, then cleared.
    reg_h_start = 12'd10; f_lines = 2; f_len[0] = 25; f_len[1] = 100;
    run_frame();
    f_len[0] = 100; run_frame();
    pulse_err_clear();

    // Zero length: fval only.
    reg_h_length = 12'd0; f_lines = 3; for (int i = 0; i < 3; i++) f_len[i] = 40;
    run_frame();

    // Extreme crop: only column 4095 of a 4096-column line is kept.
    reg_h_start = 12'd4095; reg_h_length = 12'd4095; f_lines = 1; f_len[0] = 4096;
    run_frame();
    pulse_err_clear();

    // Enable dropped mid-frame keeps that frame; next one suppressed while enable rises mid-frame; then emitted.
    reg_h_start = 12'd3; reg_h_length = 12'd7; f_lines = 3;
    for (int i = 0; i < 8; i++) f_len[i] = 20;
    f_en_line = 1; f_en_val = 1'b0; run_frame();
    f_en_line = 1; f_en_val = 1'b1; run_frame();
    f_en_line = -1; run_frame();

    // Asynchronous reset in the middle of a line, then a complete frame.
    f_rst_line = 1; f_rst_col = 5; run_frame();
    f_rst_line = -1; run_frame();
    chk("frame_cnt_after_reset", {48'd0, frame_cnt}, 64'd1);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      reg_h_start  = 12'($urandom_range(0, 40));
      reg_h_length = 12'($urandom_range(0, 40));
      f_lines = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) f_len[i] = $urandom_range(1, 60);
      if ($urandom_range(0, 3) == 0) begin
        f_en_line = $urandom_range(0, f_lines - 1);
        f_en_val  = !enable;
      end else begin
        f_en_line = -1;
      end
      run_frame();
      if (err_m && $urandom_range(0, 3) == 0) pulse_err_clear();
    end
    f_en_line = -1;

    for (int i = 0; i < 10; i++) cyc(0, 0, '0);
    chk("beats_drained",  64'(exp_beats.size()),  64'd0);
    chk("frames_drained", 64'(exp_frames.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cl_frame_formatter.md
Name: cl_frame_formatter

Overview:
Sits between image_rx and image_tx in the clk_txg domain. Takes raw 8-tap pixel data with fval/lval from the receiver and applies a per-frame horizontal crop. Produces Camera Link fval/lval/dval and the aligned tap data for the transmitter, which fills the currently unused dval path. Only whole frames pass: the block never emits a partial frame after enable, reset or a mid-frame start.

Parameters:
CHAN_W, 8, bits per tap
NUM_CHAN, 8, taps per clock
COL_W, 12, width of column/line counters and crop registers

Ports:
clk_txg  in  1  transmit-domain pixel clock
rst_tx_n  in  1  asynchronous active-low reset
enable  in  1  formatter run; sampled only at frame boundaries
reg_h_start  in  COL_W  first kept column (tap-group clocks after lval rise)
reg_h_length  in  COL_W  kept columns per line
fval_in  in  1  frame valid from image_rx
lval_in  in  1  line valid from image_rx
chan_in  in  NUM_CHAN*CHAN_W  taps, chan_0 in LSBs
err_clear  in  1  clears sticky error
fval  out  1  Camera Link frame valid
lval  out  1  Camera Link line valid (cropped)
dval  out  1  data valid (equals lval in this block)
chan_out  out  NUM_CHAN*CHAN_W  cropped taps; zero outside lval
frame_cnt  out  16  frames emitted
line_cnt  out  COL_W  lines emitted in the current frame
err_short_line  out  1  sticky: lval_in fell before the crop window ended

Behaviour:
- Reset values: all outputs 0 and state = IDLE.
- Inputs are registered once, then output registers follow. Fixed latency is 2 clk_txg cycles from input to output for every signal.
- The FSM has four states:
  - IDLE: wait for enable = 1, then go to WAIT_LOW.
  - WAIT_LOW: wait for fval_in = 0, then go to ARMED.
  - ARMED: on the fval_in rising edge, latch reg_h_start and reg_h_length into shadow registers, clear line_cnt and go to FRAME.
  - FRAME: fval = 1. On the fval_in falling edge, fval = 0 and frame_cnt is incremented (wraps at 0xFFFF→0). Then go to ARMED if enable = 1, else IDLE.
- Mid-frame enable = 0 has no effect until the frame ends.
- Column counter:
  - Cleared on each lval_in rising edge; increments every cycle while lval_in = 1.
  - Saturates at 2^COL_W-1, with no wrap.
- Crop window: lval = dval = 1 when lval_in = 1 and shadow_start <= col < shadow_start + shadow_length. The sum is computed at COL_W+1 bits, so there is no overflow.
- shadow_length = 0 gives fval only, with lval, dval and line_cnt never asserted or incremented.
- line_cnt increments on each output lval falling edge and saturates.
- Short line: lval_in falls while col < shadow_start + shadow_length and shadow_length != 0 → err_short_line = 1. Output lval drops together with the input; there is no padding.
- err_clear and a simultaneous new error: the error wins.
- lval_in asserted while fval_in = 0 is ignored, giving no output lval.
- Asynchronous reset mid-frame: outputs drop to 0 immediately, and the block resumes via IDLE → WAIT_LOW, so the first emitted frame is complete.

Optional Feature:
CL_FRAME_STAMP_EN
- Defined: on the first dval cycle of each frame, chan_out taps 0 and 1 are replaced by frame_cnt[7:0] and frame_cnt[15:8]. Remaining taps and all other cycles pass through.
- Undefined: no substitution; the stamp logic is absent.

Decomposition:
- Shared package cl_fmt_pkg holds:
  - FSM state enum (IDLE, WAIT_LOW, ARMED, FRAME);
  - constants CL_TAPS = 8 and CL_TAP_W = 8;
  - FRAME_CNT_W = 16.
- One natural sub-module: cl_line_crop. It holds the column counter, window compare, lval/dval generation and the short-line detect. The top level keeps the FSM, shadow registers, counters and the output pipeline.

Test Plan:
1. Reset, enable = 1, 3 frames of 4 lines × 100 columns, start = 10, length = 20 → each output line has exactly 20 dval cycles, with data equal to input columns 10..29 delayed 2 cycles. line_cnt = 4 per frame; frame_cnt = 3.
2. enable rises mid-frame → that frame is suppressed (fval stays 0), and the next frame is emitted in full with frame_cnt = 1.
3. reg_h_start changed mid-frame from 10 to 50 → the current frame keeps crop 10; the next frame crops from column 50.
4. Input line of 25 columns with start = 10, length = 20 → lval is 15 cycles and err_short_line = 1 and stays set. Pulse err_clear → 0.
5. length = 0 → fval toggles normally, lval/dval stay 0, line_cnt = 0. start = 4095, length = 4095 → no overflow, dval only at column 4095.
6. With CL_FRAME_STAMP_EN defined, frame_cnt = 0x1234 → the first dval cycle has tap 0 = 0x34 and tap 1 = 0x12, and later cycles are unmodified.
